// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 transmitter.
//
// Sends one command byte (e.g. 0xED set LEDs, 0xFF reset) to a PS/2 device:
// inhibit (CLK low), request-to-send (DAT low, CLK released), eleven
// device-clocked bits (data LSB first, odd parity, stop, ack), then a wait
// for both lines to return high. The lines are open-drain: an oe output of 1
// pulls the line low, 0 releases it.
//
// Handshake: a command is accepted on any clock where cmd_valid & cmd_ready.
// cmd_ready is high only in IDLE, so a request made while busy is not queued.
// A cmd_valid held high is taken again on the first IDLE cycle after a
// command finishes.
//
// Ports:
//   CLOCK_50    in   system clock (50 MHz)
//   reset       in   asynchronous active-high reset, releases both lines
//   cmd_data    in   [7:0] byte to send, latched on accept
//   cmd_valid   in   request to send cmd_data
//   cmd_ready   out  high in IDLE
//   busy        out  high from accept until back in IDLE
//   cmd_sent    out  one-cycle pulse: frame sent and ack seen
//   cmd_error   out  one-cycle pulse: timeout or missing ack
//   error_code  out  [1:0] 1 start timeout, 2 transfer timeout, 3 no ack
//   ps2_clk_in  in   raw PS2_CLK pin (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT pin (asynchronous)
//   ps2_clk_oe  out  1 pulls PS2_CLK low
//   ps2_dat_oe  out  1 pulls PS2_DAT low
//   fsm_state   out  [2:0] current FSM state, debug visibility only
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5500,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       cmd_sent,
    output logic       cmd_error,
    output logic [1:0] error_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INHIBIT    = 3'd1,
        S_REQ        = 3'd2,
        S_WAIT_START = 3'd3,
        S_XFER       = 3'd4,
        S_WAIT_IDLE  = 3'd5
    } state_t;

    // CLK is held low for INHIBIT_CYCLES cycles in total; the last of them
    // is the REQ overlap cycle, so INHIBIT itself lasts one cycle less.
    localparam logic [19:0] INH_LIM   = 20'(INHIBIT_CYCLES - 2);
    localparam logic [19:0] START_LIM = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] XFER_LIM  = 20'(XFER_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic        clk_meta, clk_sync, clk_prev;
    logic        dat_meta, dat_sync;
    logic        fall;

    logic [8:0]  shift;      // {parity, data}, consumed LSB first
    logic        dat_low;    // level being driven on DAT during XFER
    logic [3:0]  edge_cnt;
    logic [19:0] tcnt;
    logic [19:0] tcnt_inc;

    logic        sent_next;
    logic        err_next;
    logic [1:0]  err_code_next;

    // Pins idle high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
        end
    end

    assign fall     = clk_prev & ~clk_sync;
    assign tcnt_inc = (tcnt == 20'hFFFFF) ? tcnt : tcnt + 20'd1;

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic, including the completion/error decisions.
    always_comb begin
        state_next    = state;
        sent_next     = 1'b0;
        err_next      = 1'b0;
        err_code_next = 2'd0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) state_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (tcnt >= INH_LIM) state_next = S_REQ;
            end
            S_REQ: begin
                state_next = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (fall) begin
                    state_next = S_XFER;
                end else if (tcnt >= START_LIM) begin
                    state_next    = S_IDLE;
                    err_next      = 1'b1;
                    err_code_next = 2'd1;
                end
            end
            S_XFER: begin
                if (tcnt >= XFER_LIM) begin
                    state_next    = S_IDLE;
                    err_next      = 1'b1;
                    err_code_next = 2'd2;
                end else if (fall && edge_cnt == 4'd10) begin
                    // 11th fall: device ack must hold DAT low.
                    if (dat_sync) begin
                        state_next    = S_IDLE;
                        err_next      = 1'b1;
                        err_code_next = 2'd3;
                    end else begin
                        state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (tcnt >= XFER_LIM) begin
                    state_next    = S_IDLE;
                    err_next      = 1'b1;
                    err_code_next = 2'd2;
                end else if (clk_sync && dat_sync) begin
                    state_next = S_IDLE;
                    sent_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; line drive drops as soon as state leaves
    // a driving state, including on asynchronous reset.
    always_comb begin
        cmd_ready  = (state == S_IDLE);
        busy       = (state != S_IDLE);
        ps2_clk_oe = (state == S_INHIBIT) || (state == S_REQ);
        ps2_dat_oe = (state == S_REQ) || (state == S_WAIT_START) ||
                     ((state == S_XFER) && dat_low);
    end

    assign fsm_state = state;

    // Datapath: counters, shift register, result pulses.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            shift      <= '0;
            dat_low    <= 1'b0;
            edge_cnt   <= '0;
            tcnt       <= '0;
            cmd_sent   <= 1'b0;
            cmd_error  <= 1'b0;
            error_code <= 2'd0;
        end else begin
            cmd_sent  <= sent_next;
            cmd_error <= err_next;
            if (err_next) error_code <= err_code_next;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        shift      <= {~^cmd_data, cmd_data};
                        edge_cnt   <= '0;
                        tcnt       <= '0;
                        error_code <= 2'd0;
                    end
                end
                S_INHIBIT: tcnt <= tcnt_inc;
                S_REQ:     tcnt <= '0;
                S_WAIT_START: begin
                    if (fall) begin
                        edge_cnt <= 4'd1;
                        tcnt     <= '0;
                        dat_low  <= ~shift[0];
                        shift    <= {1'b1, shift[8:1]};
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_XFER: begin
                    tcnt <= tcnt_inc;
                    if (fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        // Ones shift in behind parity, so the 10th fall
                        // releases DAT for the stop bit.
                        dat_low  <= ~shift[0];
                        shift    <= {1'b1, shift[8:1]};
                    end
                end
                S_WAIT_IDLE: tcnt <= tcnt_inc;
                default: ;
            endcase
        end
    end

endmodule
